wb_stage_multi: RTL

//  Parametrised multi-lane write-back stage: last pipeline stage of the LoongArch core, after mem stage.

---
 rtl/wb_stage_multi_if.sv | 32 +++
 rtl/wb_stage_multi.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_multi_if.sv
// wb_stage_multi_if: mem-stage to write-back-stage bundle bus.
//   master : mem stage, drives the bundle and samples ws_allowin
//   slave  : write-back stage, samples the bundle and drives ws_allowin
// Signals: ms_to_ws_valid, ms_lane_valid, ms_pc, ms_gr_we, ms_dest, ms_result,
//          ms_inst_csr, ms_excp, ms_ertn (mem -> wb); ws_allowin (wb -> mem).
interface wb_stage_multi_if #(
  parameter int unsigned LANES   = 2,
  parameter int unsigned ECODE_W = 14
);
  logic                       ms_to_ws_valid;
  logic [LANES-1:0]           ms_lane_valid;
  logic [LANES*32-1:0]        ms_pc;
  logic [LANES-1:0]           ms_gr_we;
  logic [LANES*5-1:0]         ms_dest;
  logic [LANES*32-1:0]        ms_result;
  logic [LANES-1:0]           ms_inst_csr;
  logic [LANES*ECODE_W-1:0]   ms_excp;
  logic [LANES-1:0]           ms_ertn;
  logic                       ws_allowin;

  modport master (
    output ms_to_ws_valid, ms_lane_valid, ms_pc, ms_gr_we, ms_dest, ms_result,
           ms_inst_csr, ms_excp, ms_ertn,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid, ms_lane_valid, ms_pc, ms_gr_we, ms_dest, ms_result,
           ms_inst_csr, ms_excp, ms_ertn,
    output ws_allowin
  );
endinterface

// File: rtl/wb_stage_multi.sv
// wb_stage_multi: multi-lane write-back stage (last stage after mem).
// Latches a LANES-wide bundle, commits GR writes in lane order, reports the
// oldest exception/ertn to CSR and feeds the single-port debug trace.
// Optional feature macro: WS_TRACE_FIFO_EN
//   defined   : trace FIFO of TRACE_DEPTH entries serialises commits; the
//               stage stalls until the FIFO has room for a whole bundle.
//   undefined : no FIFO, never stalls; trace shows the lowest writing lane.
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   ms_bus (slave)        bundle from mem stage, ws_allowin back
//   csr_rdata             CSR read data used by lane 0 csr instructions
//   rf_we/waddr/wdata     LANES GR write ports (also forwarding to decode)
//   ws_exception          flush pulse to earlier stages
//   excp_valid/ertn_flush exception / ertn commit to CSR
//   excp_code/excp_pc     code and PC of the flushing lane
//   debug_wb_*            debug trace port
module wb_stage_multi #(
  parameter int unsigned LANES       = 2,
`ifdef WS_TRACE_FIFO_EN
  parameter int unsigned TRACE_DEPTH = 4,
`endif
  parameter int unsigned ECODE_W     = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  wb_stage_multi_if.slave       ms_bus,
  input  logic [31:0]           csr_rdata,
  output logic [LANES-1:0]      rf_we,
  output logic [LANES*5-1:0]    rf_waddr,
  output logic [LANES*32-1:0]   rf_wdata,
  output logic                  ws_exception,
  output logic                  excp_valid,
  output logic                  ertn_flush,
  output logic [ECODE_W-1:0]    excp_code,
  output logic [31:0]           excp_pc,
  output logic [31:0]           debug_wb_pc,
  output logic [3:0]            debug_wb_rf_we,
  output logic [4:0]            debug_wb_rf_wnum,
  output logic [31:0]           debug_wb_rf_wdata
);

  localparam int unsigned LANE_W = $clog2(LANES + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trace_t;

  // Bundle registers
  logic                       ws_valid_q;
  logic [LANES-1:0]           lane_valid_q;
  logic [LANES*32-1:0]        pc_q;
  logic [LANES-1:0]           gr_we_q;
  logic [LANES*5-1:0]         dest_q;
  logic [LANES*32-1:0]        result_q;
  logic                       inst_csr_q;
  logic [LANES*ECODE_W-1:0]   excp_q;
  logic [LANES-1:0]           ertn_q;

  logic                       ws_ready_go;
  logic                       fire;
  logic                       kill_found;
  logic [LANE_W-1:0]          kill_idx;
  logic                       kill_is_excp;
  logic [ECODE_W-1:0]         kill_code;
  logic [31:0]                kill_pc;
  logic [LANES-1:0]           we_raw;

  assign ms_bus.ws_allowin = !ws_valid_q || ws_ready_go;
  assign fire              = ws_valid_q && ws_ready_go;

  // Bundle latch; a bundle occupies the stage for exactly one firing cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_valid_q   <= 1'b0;
      lane_valid_q <= '0;
      pc_q         <= '0;
      gr_we_q      <= '0;
      dest_q       <= '0;
      result_q     <= '0;
      inst_csr_q   <= 1'b0;
      excp_q       <= '0;
      ertn_q       <= '0;
    end else if (ms_bus.ws_allowin) begin
      ws_valid_q <= ms_bus.ms_to_ws_valid;
      if (ms_bus.ms_to_ws_valid) begin
        lane_valid_q <= ms_bus.ms_lane_valid;
        pc_q         <= ms_bus.ms_pc;
        gr_we_q      <= ms_bus.ms_gr_we;
        dest_q       <= ms_bus.ms_dest;
        result_q     <= ms_bus.ms_result;
        inst_csr_q   <= ms_bus.ms_inst_csr[0];
        excp_q       <= ms_bus.ms_excp;
        ertn_q       <= ms_bus.ms_ertn;
      end
    end
  end

  // Oldest killing lane: descending scan so the lowest index wins
  always_comb begin
    kill_found   = 1'b0;
    kill_idx     = '0;
    kill_is_excp = 1'b0;
    kill_code    = '0;
    kill_pc      = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (lane_valid_q[i] && (excp_q[i*ECODE_W +: ECODE_W] != '0 || ertn_q[i])) begin
        kill_found   = 1'b1;
        kill_idx     = LANE_W'(i);
        kill_is_excp = (excp_q[i*ECODE_W +: ECODE_W] != '0);
        kill_code    = excp_q[i*ECODE_W +: ECODE_W];
        kill_pc      = pc_q[i*32 +: 32];
      end
    end
  end

  // Exception / ertn commit; an exception on the same lane outranks ertn
  always_comb begin
    excp_valid   = fire && kill_found && kill_is_excp;
    ertn_flush   = fire && kill_found && !kill_is_excp;
    ws_exception = excp_valid || ertn_flush;
    excp_code    = ws_exception ? kill_code : '0;
    excp_pc      = ws_exception ? kill_pc   : '0;
  end

  // GR write enables: only lanes older than the kill, younger lane wins a dest clash
  always_comb begin
    we_raw = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      we_raw[i] = fire && lane_valid_q[i] && gr_we_q[i] &&
                  (!kill_found || (LANE_W'(i) < kill_idx)) &&
                  (dest_q[i*5 +: 5] != 5'd0);
    end
    rf_we = we_raw;
    for (int i = 0; i < int'(LANES); i++) begin
      for (int j = 0; j < int'(LANES); j++) begin
        if (j > i && we_raw[j] && dest_q[j*5 +: 5] == dest_q[i*5 +: 5]) begin
          rf_we[i] = 1'b0;
        end
      end
    end
  end

  assign rf_waddr = dest_q;

  always_comb begin
    rf_wdata = result_q;
    if (inst_csr_q) begin
      rf_wdata[31:0] = csr_rdata;
    end
  end

`ifdef WS_TRACE_FIFO_EN
  localparam int unsigned IDX_W = $clog2(TRACE_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  trace_t             mem_q [TRACE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   count;
  logic [PTR_W:0]     free;
  logic               fifo_empty;
  logic [PTR_W-1:0]   slot [LANES];
  logic [PTR_W-1:0]   push_cnt;
  trace_t             dbg_q, dbg_d;
  logic [3:0]         dbg_we_q, dbg_we_d;

  assign count       = wr_ptr_q - rd_ptr_q;
  assign free        = (PTR_W+1)'(TRACE_DEPTH) - (PTR_W+1)'(count);
  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign ws_ready_go = (free >= (PTR_W+1)'(LANES));

  // Pack writing lanes into consecutive FIFO slots in ascending lane order
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      slot[i] = push_cnt;
      if (rf_we[i]) begin
        push_cnt = push_cnt + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LANES); i++) begin
      if (rf_we[i]) begin
        mem_q[IDX_W'(wr_ptr_q + slot[i])] <= '{pc:    pc_q[i*32 +: 32],
                                               wnum:  dest_q[i*5 +: 5],
                                               wdata: rf_wdata[i*32 +: 32]};
      end
    end
  end

  // Pop one head entry per cycle into the registered debug port
  always_comb begin
    wr_ptr_d = wr_ptr_q + push_cnt;
    rd_ptr_d = rd_ptr_q;
    dbg_d    = dbg_q;
    dbg_we_d = 4'h0;
    if (!fifo_empty) begin
      dbg_d    = mem_q[rd_ptr_q[IDX_W-1:0]];
      dbg_we_d = 4'hf;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dbg_q    <= '0;
      dbg_we_q <= 4'h0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dbg_q    <= dbg_d;
      dbg_we_q <= dbg_we_d;
    end
  end

  assign debug_wb_pc       = dbg_q.pc;
  assign debug_wb_rf_we    = dbg_we_q;
  assign debug_wb_rf_wnum  = dbg_q.wnum;
  assign debug_wb_rf_wdata = dbg_q.wdata;
`else
  assign ws_ready_go = 1'b1;

  // Bring-up trace: lowest writing lane only, shown in the commit cycle
  always_comb begin
    debug_wb_pc       = '0;
    debug_wb_rf_we    = 4'h0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (rf_we[i]) begin
        debug_wb_pc       = pc_q[i*32 +: 32];
        debug_wb_rf_we    = 4'hf;
        debug_wb_rf_wnum  = dest_q[i*5 +: 5];
        debug_wb_rf_wdata = rf_wdata[i*32 +: 32];
      end
    end
  end
`endif

endmodule
